// File: rtl/ped_pkg.sv
// ped_pkg: shared FSM state encoding and served-count width for the pedestrian request unit.
package ped_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    SERVING = 2'b10
  } ped_state_e;
  localparam int SERVED_W = 8;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser, stability-count debounce and registered press pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  logic [1:0] sync_q;
  logic deb_q, deb_d, press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hit;
  assign hit = (sync_q[1] != deb_q) && ((cnt_q + 1'b1) == CMAX);
  always_comb begin
    cnt_d   = (sync_q[1] == deb_q || hit) ? '0 : cnt_q + 1'b1;
    deb_d   = hit ? sync_q[1] : deb_q;
    press_d = hit && sync_q[1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end
  assign level_o = deb_q;
  assign press_o = press_q;
endmodule

// File: rtl/ped_request_unit.sv
// ped_request_unit: debounced crossing request FSM with WAIT lamp, beeper, served counter and fault flags.
module ped_request_unit
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BEEP_DIV        = 2,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button_raw,
  input  logic                red_p,
  input  logic                yellow_p,
  input  logic                green_p,
  output logic                button,
  output logic                wait_lamp,
  output logic                beep,
  output logic [SERVED_W-1:0] served_count,
  output logic                lamp_fault,
  output logic                timeout_fault
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BEEP_DIV + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BMAX = BW'(BEEP_DIV);
  ped_state_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] bdiv_q, bdiv_d;
  logic beep_q, beep_d, tfault_q, tfault_d, lfault_q, lfault_d, press, level;
  logic [SERVED_W-1:0] served_q, served_d;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (button_raw),
    .level_o(level),
    .press_o(press)
  );
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    bdiv_d   = bdiv_q;
    beep_d   = beep_q;
    served_d = served_q;
    tfault_d = tfault_q;
    lfault_d = lfault_q || ({red_p, yellow_p, green_p} != 3'b100 &&
                            {red_p, yellow_p, green_p} != 3'b010 &&
                            {red_p, yellow_p, green_p} != 3'b001);
    unique case (state_q)
      IDLE: if (press && !green_p) begin
        state_d = PENDING;
        tmo_d   = '0;
      end
      PENDING: if (green_p) begin
        state_d = SERVING;
        bdiv_d  = '0;
        beep_d  = 1'b0;
      end else if (tmo_q != TMAX) begin
        tmo_d    = tmo_q + 1'b1;
        tfault_d = tfault_q || (tmo_d == TMAX);
      end
      SERVING: if (!green_p) begin
        state_d  = IDLE;
        beep_d   = 1'b0;
        served_d = (served_q == '1) ? served_q : served_q + 1'b1;
      end else begin
        bdiv_d = ((bdiv_q + 1'b1) == BMAX) ? '0 : bdiv_q + 1'b1;
        beep_d = ((bdiv_q + 1'b1) == BMAX) ? !beep_q : beep_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      bdiv_q   <= '0;
      beep_q   <= 1'b0;
      served_q <= '0;
      tfault_q <= 1'b0;
      lfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      bdiv_q   <= bdiv_d;
      beep_q   <= beep_d;
      served_q <= served_d;
      tfault_q <= tfault_d;
      lfault_q <= lfault_d;
    end
  end
  assign button        = (state_q == PENDING);
  assign wait_lamp     = (state_q == PENDING);
  assign beep          = beep_q;
  assign served_count  = served_q;
  assign lamp_fault    = lfault_q;
  assign timeout_fault = tfault_q;
endmodule

// File: tb/tb_ped_request_unit.sv
// tb_ped_request_unit: directed and randomized checks against a cycle-level behavioural model.
module tb_ped_request_unit;
  localparam int D = 4, B = 2, T = 16;
  logic clk = 1'b0, rst = 1'b1, raw = 1'b0, r = 1'b1, y = 1'b0, g = 1'b0;
  logic button, wait_lamp, beep, lamp_fault, timeout_fault;
  logic [7:0] served_count;
  int n_chk = 0, n_fail = 0;
  int m_q0, m_q1, m_deb, m_run, m_press, m_mode, m_pk, m_sk, m_served, m_lf, m_tf;
  ped_request_unit #(.DEBOUNCE_CYCLES(D), .BEEP_DIV(B), .TIMEOUT_CYCLES(T)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .button_raw   (raw),
    .red_p        (r),
    .yellow_p     (y),
    .green_p      (g),
    .button       (button),
    .wait_lamp    (wait_lamp),
    .beep         (beep),
    .served_count (served_count),
    .lamp_fault   (lamp_fault),
    .timeout_fault(timeout_fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_q0 = 0; m_q1 = 0; m_deb = 0; m_run = 0; m_press = 0; m_mode = 0;
    m_pk = 0; m_sk = 0; m_served = 0; m_lf = 0; m_tf = 0;
  endtask
  // Model: mode 0 idle, 1 waiting for grant, 2 crossing in progress.
  task automatic m_step();
    int s;
    if (rst) begin
      m_reset();
      return;
    end
    s = m_q1;
    case (m_mode)
      0: if (m_press != 0 && !g) begin m_mode = 1; m_pk = 0; end
      1: if (g) begin m_mode = 2; m_sk = 0; end
         else begin m_pk++; if (m_pk >= T) m_tf = 1; end
      default: if (!g) begin m_mode = 0; if (m_served < 255) m_served++; end
         else m_sk++;
    endcase
    if ($countones({r, y, g}) != 1) m_lf = 1;
    m_press = 0;
    if (s == m_deb) m_run = 0;
    else begin
      m_run++;
      if (m_run == D) begin m_deb = s; m_run = 0; m_press = s; end
    end
    m_q1 = m_q0;
    m_q0 = int'(raw);
  endtask
  task automatic check_all();
    chk("button", 8'(button), 8'(m_mode == 1));
    chk("wait_lamp", 8'(wait_lamp), 8'(m_mode == 1));
    chk("beep", 8'(beep), (m_mode == 2) ? 8'((m_sk / B) % 2) : 8'd0);
    chk("served_count", served_count, 8'(m_served));
    chk("lamp_fault", 8'(lamp_fault), 8'(m_lf));
    chk("timeout_fault", 8'(timeout_fault), 8'(m_tf));
  endtask
  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_button"}, 8'(button), 8'd0);
    chk({tag, "_wait"}, 8'(wait_lamp), 8'd0);
    chk({tag, "_beep"}, 8'(beep), 8'd0);
    chk({tag, "_served"}, served_count, 8'd0);
    chk({tag, "_lamp_fault"}, 8'(lamp_fault), 8'd0);
    chk({tag, "_timeout_fault"}, 8'(timeout_fault), 8'd0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
  endtask
  task automatic crossing(input int green_len);
    raw = 1'b1;
    for (int k = 0; k < 20 && !button; k++) tick();
    chk("crossing_request", 8'(button), 8'd1);
    raw = 1'b0;
    {r, y, g} = 3'b001;
    for (int k = 0; k < green_len; k++) tick();
    {r, y, g} = 3'b100;
    for (int k = 0; k < 7; k++) tick();
  endtask
  initial begin
    logic [7:0] pat;
    m_reset();
    do_reset();
    // Latency: raw high from edge 0, request visible only after edge 6.
    raw = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("latency_early_button", 8'(button), 8'd0);
    tick();
    chk("latency_button", 8'(button), 8'd1);
    chk("latency_wait", 8'(wait_lamp), 8'd1);
    // Timeout: 16 pending cycles without grant.
    raw = 1'b0;
    for (int k = 0; k < T - 1; k++) tick();
    chk("timeout_early", 8'(timeout_fault), 8'd0);
    tick();
    chk("timeout_set", 8'(timeout_fault), 8'd1);
    chk("timeout_button_held", 8'(button), 8'd1);
    tick();
    // Grant: 8 green cycles, press during green is dropped.
    {r, y, g} = 3'b001;
    raw = 1'b1;
    pat = 8'b1100_1100;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("serve_button_low", 8'(button), 8'd0);
      chk("beep_pattern", 8'(beep), 8'(pat[i]));
    end
    {r, y, g} = 3'b100;
    tick();
    chk("served_one", served_count, 8'd1);
    chk("timeout_sticky", 8'(timeout_fault), 8'd1);
    for (int k = 0; k < 4; k++) tick();
    chk("dropped_press", 8'(button), 8'd0);
    raw = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    // Lamp fault: 3'b011 for one cycle.
    {r, y, g} = 3'b011;
    tick();
    {r, y, g} = 3'b100;
    chk("lamp_fault_set", 8'(lamp_fault), 8'd1);
    for (int k = 0; k < 5; k++) tick();
    chk("lamp_fault_sticky", 8'(lamp_fault), 8'd1);
    chk("lamp_served", served_count, 8'd1);
    // Glitch: 3 raw cycles yield no press.
    do_reset();
    raw = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("glitch_button", 8'(button), 8'd0);
      chk("glitch_debounced", 8'(u_dut.u_deb.deb_q), 8'd0);
    end
    // Randomized lamps and button.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(5) == 0) raw = ~raw;
      if ($urandom_range(9) == 0) begin
        case ($urandom_range(2))
          0: {r, y, g} = 3'b100;
          1: {r, y, g} = 3'b010;
          default: {r, y, g} = 3'b001;
        endcase
        if (k > 450 && $urandom_range(15) == 0) {r, y, g} = 3'($urandom_range(7));
      end
      tick();
    end
    // Reset mid-serving.
    {r, y, g} = 3'b100;
    raw = 1'b0;
    do_reset();
    for (int k = 0; k < 8; k++) tick();
    raw = 1'b1;
    for (int k = 0; k < 20 && !button; k++) tick();
    raw = 1'b0;
    {r, y, g} = 3'b001;
    for (int k = 0; k < 4; k++) tick();
    chk("mid_serving_beep", 8'(beep), 8'd1);
    #2 rst = 1'b1;
    m_reset();
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    {r, y, g} = 3'b100;
    tick();
    chk("after_reset_served", served_count, 8'd0);
    for (int k = 0; k < 8; k++) tick();
    // Saturation: 256 crossings.
    for (int n = 0; n < 256; n++) crossing(1 + (n % 3));
    chk("served_saturated", served_count, 8'd255);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ped_request_unit.md
Name: ped_request_unit

Overview:
- Pedestrian-side companion to the crossing light controller. Consumes the raw push-button and the pedestrian lamp outputs (red_p/yellow_p/green_p); drives the controller's `button` input.
- Synchronises and debounces the raw button, then latches a crossing request and holds `button` high until the controller grants green_p.
- Drives a WAIT lamp and a crossing beeper, counts served crossings, and flags lamp/timeout faults.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a new button level (>=1).
- BEEP_DIV, 2: beep toggles every BEEP_DIV cycles while serving (>=1).
- TIMEOUT_CYCLES, 16: maximum cycles in PENDING before a timeout fault (>=1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- button_raw  input  1  raw, asynchronous, bouncy push-button
- red_p  input  1  pedestrian red lamp from controller
- yellow_p  input  1  pedestrian yellow lamp from controller
- green_p  input  1  pedestrian green lamp from controller
- button  output  1  registered crossing request to controller
- wait_lamp  output  1  registered WAIT indicator
- beep  output  1  registered audible crossing tone
- served_count  output  8  crossings completed, saturating
- lamp_fault  output  1  sticky fault: pedestrian lamps not one-hot
- timeout_fault  output  1  sticky fault: request not granted in time

Behaviour:
- Reset (async, immediate): FSM=IDLE; synchroniser flops=0; debounced level=0; counters=0; all outputs=0.
- Synchroniser: two flops on button_raw. The debounce stage sees only the second flop.
- Debounce:
  - Counter increments each cycle while sync != debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, debounced takes the sync value and the counter clears.
  - press = single-cycle pulse on the debounced 0->1 transition.
  - Latency: raw held high from edge 0 gives debounced=1 after edge DEBOUNCE_CYCLES+1, and FSM=PENDING with button=1 after edge DEBOUNCE_CYCLES+2 (edge 6 at default).
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no press.
- FSM IDLE:
  - Outputs: button=0, wait_lamp=0, beep=0.
  - press && !green_p goes to PENDING.
  - press while green_p=1 is ignored: a crossing is already in progress.
- FSM PENDING:
  - Outputs: button=1, wait_lamp=1.
  - The timeout counter counts cycles in PENDING.
  - green_p=1 goes to SERVING.
  - If the counter reaches TIMEOUT_CYCLES with green_p still 0: set timeout_fault and stay in PENDING with the request held.
- FSM SERVING:
  - Outputs: button=0, wait_lamp=0.
  - beep toggles every BEEP_DIV cycles, starting at 0 on entry.
  - green_p=0 goes to IDLE, beep forced to 0, and served_count increments, saturating at 255.
  - press during SERVING is dropped, not queued.
- Simultaneous events:
  - green_p rising in the same cycle as press in IDLE: treat as green_p=1, so the press is ignored.
  - Timeout and grant in the same cycle: the grant wins and no fault is set.
- Lamp check:
  - Registered every cycle, in all states: lamp_fault sets when {red_p,yellow_p,green_p} is not exactly one-hot.
  - Sticky until rst. A fault does not alter FSM behaviour.
- Reset mid-request: rst during PENDING or SERVING drops button/wait_lamp/beep immediately (async). served_count is not incremented.
- Widths: internal counters are sized as $clog2(param+1). served_count holds at 8'hFF.

Decomposition:
- Shared package ped_pkg:
  - FSM state typedef: IDLE=2'b00, PENDING=2'b01, SERVING=2'b10.
  - served_count width constant, 8.
- Sub-module button_debouncer (synchroniser + debounce + press pulse), parameterised by DEBOUNCE_CYCLES.
- FSM, beep divider, counters and fault logic live in ped_request_unit.

Test Plan:
1. Raw button high from edge 0, lamps red_p=1 → button=1 and wait_lamp=1 exactly after edge 6, beep=0, no faults.
2. 3-cycle raw glitch at default → button never asserts, and debounced stays 0.
3. PENDING, then green_p=1 for 8 cycles, then red_p=1:
   - button drops the cycle after green_p is sampled.
   - beep pattern is 0,0,1,1,0,0,1,1.
   - served_count goes 0→1 after green_p falls.
   - Presses during green_p are dropped, and FSM returns to IDLE.
4. PENDING held 16 cycles with green_p=0 → timeout_fault=1 and button stays 1. A grant later still serves, and the fault stays set.
5. Lamp input 3'b011 for one cycle → lamp_fault=1 after the next edge and remains 1 until rst. served_count is unaffected.
6. rst pulse mid-SERVING → all outputs 0 asynchronously; after release, FSM=IDLE and served_count unchanged. Also run 256 crossings → served_count saturates at 255.
